// File: rtl/top.sv
// UART LED controller: 8N1 receiver drives five LEDs, optional echo (ECHO_EN).
// Ports: clk, resetn (sync, active-low), rx (async in), tx (out), led[4:0].
module top #(
  parameter int CLK_HZ = 12000000,
  parameter int BAUD   = 1000000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rx,
  output logic       tx,
  output logic [4:0] led
);

  localparam int CPB  = CLK_HZ / BAUD;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB + 1);
  localparam logic [CW-1:0] LAST = CW'(CPB - 1);
  localparam logic [CW-1:0] MID  = CW'(HALF - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } st_t;

  logic rx_m, rx_s, rx_d;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  st_t           rs;
  logic [CW-1:0] rc;
  logic [2:0]    rb;
  logic [7:0]    rsh;
  logic          rerr;
  logic          rv;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rs   <= IDLE;
      rc   <= '0;
      rb   <= '0;
      rsh  <= '0;
      rerr <= 1'b0;
      rv   <= 1'b0;
    end else begin
      rv <= 1'b0;
      unique case (rs)
        IDLE: begin
          rc   <= '0;
          rb   <= '0;
          rerr <= 1'b0;
          if (rx_d && !rx_s) rs <= START;
        end
        START: begin
          if (rc == MID) begin
            rc <= '0;
            rs <= rx_s ? IDLE : DATA;
          end else begin
            rc <= rc + 1'b1;
          end
        end
        DATA: begin
          if (rc == LAST) begin
            rc  <= '0;
            rsh <= {rx_s, rsh[7:1]};
            rb  <= rb + 3'd1;
            if (rb == 3'd7) rs <= STOP;
          end else begin
            rc <= rc + 1'b1;
          end
        end
        STOP: begin
          if (rerr) begin
            // framing error: hold off until the line idles
            if (rx_s) rs <= IDLE;
          end else if (rc == LAST) begin
            rc <= '0;
            if (rx_s) begin
              rv <= 1'b1;
              rs <= IDLE;
            end else begin
              rerr <= 1'b1;
            end
          end else begin
            rc <= rc + 1'b1;
          end
        end
        default: rs <= IDLE;
      endcase
    end
  end

  // rsh stays stable in IDLE, so it is the byte during rv
  always_ff @(posedge clk) begin
    if (!resetn) begin
      led <= '0;
    end else if (rv) begin
      unique case (1'b1)
        (rsh >= 8'h30 && rsh <= 8'h34):
          led <= led ^ (5'd1 << rsh[2:0]);
        (rsh == 8'h35): led <= '0;
        (rsh == 8'h36): led <= '1;
        default: led <= led;
      endcase
    end
  end

`ifdef ECHO_EN
  st_t           ts;
  logic [CW-1:0] tc;
  logic [2:0]    tb;
  logic [7:0]    tsh;
  logic          hf;
  logic [7:0]    hb;
  logic          txr;
  logic          tdone;

  assign tdone = (ts == STOP) && (tc == LAST);
  assign tx    = txr;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ts  <= IDLE;
      tc  <= '0;
      tb  <= '0;
      tsh <= '0;
      hf  <= 1'b0;
      hb  <= '0;
      txr <= 1'b1;
    end else begin
      unique case (ts)
        IDLE: begin
          tc  <= '0;
          tb  <= '0;
          txr <= 1'b1;
          if (rv) begin
            tsh <= rsh;
            ts  <= START;
            txr <= 1'b0;
          end
        end
        START: begin
          if (tc == LAST) begin
            tc  <= '0;
            ts  <= DATA;
            txr <= tsh[0];
          end else begin
            tc <= tc + 1'b1;
          end
        end
        DATA: begin
          if (tc == LAST) begin
            tc <= '0;
            if (tb == 3'd7) begin
              tb  <= '0;
              ts  <= STOP;
              txr <= 1'b1;
            end else begin
              tb  <= tb + 3'd1;
              tsh <= {1'b0, tsh[7:1]};
              txr <= tsh[1];
            end
          end else begin
            tc <= tc + 1'b1;
          end
        end
        STOP: begin
          if (tc == LAST) begin
            tc <= '0;
            if (hf) begin
              tsh <= hb;
              hf  <= 1'b0;
              ts  <= START;
              txr <= 1'b0;
            end else if (rv) begin
              tsh <= rsh;
              ts  <= START;
              txr <= 1'b0;
            end else begin
              ts <= IDLE;
            end
          end else begin
            tc <= tc + 1'b1;
          end
        end
        default: ts <= IDLE;
      endcase
      // Hold when busy and slot free, or when the slot
      // empties into the next frame at the same edge.
      if (rv && ts != IDLE && (tdone == hf)) begin
        hb <= rsh;
        hf <= 1'b1;
      end
    end
  end
`else
  assign tx = 1'b1;
`endif

endmodule

// File: tb/tb_top.sv
// Bench for top: random and directed UART frames vs. a byte-level model.
// Checks LED state, echo content/order, glitch, framing error, reset.
module tb_top;

  localparam int CPB  = 12;
  localparam int HALF = CPB / 2;

  logic       clk = 1'b0;
  logic       resetn;
  logic       rx;
  logic       tx;
  logic [4:0] led;

  int compared = 0;
  int mism = 0;
  int cyc = 0;
  int first_fall = -1;
  int stop_cyc = 0;

  logic [4:0] mled;
  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];

  top dut (
    .clk   (clk),
    .resetn(resetn),
    .rx    (rx),
    .tx    (tx),
    .led   (led)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mism++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, got, exp);
    end
  endtask

  function automatic logic [4:0] lednext(
      input logic [4:0] l, input logic [7:0] b);
    if (b >= 8'h30 && b <= 8'h34)
      return l ^ (5'd1 << (b - 8'h30));
    if (b == 8'h35) return 5'd0;
    if (b == 8'h36) return 5'h1f;
    return l;
  endfunction

  task automatic send(input logic [7:0] b,
                      input logic stop);
    @(negedge clk) rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    stop_cyc = cyc;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    if (!stop) repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic model(input logic [7:0] b);
    mled = lednext(mled, b);
`ifdef ECHO_EN
    exp_q.push_back({1'b1, b});
`endif
  endtask

  task automatic send_chk(input string tag,
                          input logic [7:0] b);
    send(b, 1'b1);
    model(b);
    repeat (2) @(negedge clk);
    chk(tag, 32'(led), 32'(mled));
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 60 * CPB; i++) begin
      if (got_q.size() == exp_q.size()) break;
      @(negedge clk);
    end
    repeat (2 * CPB) @(negedge clk);
    chk(tag, got_q.size(), exp_q.size());
    chk({tag, "_tx"}, 32'(tx), 32'd1);
  endtask

  // decode every frame seen on tx
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge tx);
      if (first_fall < 0) first_fall = cyc;
      repeat (HALF) @(posedge clk);
      #1;
      if (tx !== 1'b0) continue;
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(posedge clk);
        #1 b[i] = tx;
      end
      repeat (CPB) @(posedge clk);
      #1 got_q.push_back({tx, b});
    end
  end

  initial begin
    int d;
    logic [7:0] b;
    int n;
    rx = 1'b1;
    resetn = 1'b0;
    mled = '0;
    repeat (3) @(negedge clk);
    chk("rst_led", 32'(led), 32'd0);
    chk("rst_tx", 32'(tx), 32'd1);
    resetn = 1'b1;
    repeat (5) @(negedge clk);

    send_chk("led_31", 8'h31);
`ifdef ECHO_EN
    d = first_fall - stop_cyc;
    chk("echo_lat", 32'(d >= HALF && d <= CPB + 2), 32'd1);
`endif
    send_chk("led_31b", 8'h31);
    send_chk("led_36", 8'h36);
    send_chk("led_35", 8'h35);
    send_chk("led_41", 8'h41);

    send(8'h30, 1'b0);
    repeat (2) @(negedge clk);
    chk("ferr_led", 32'(led), 32'(mled));
    send_chk("led_30", 8'h30);

    @(negedge clk) rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    chk("glitch", 32'(led), 32'(mled));
    drain("drain1");

    for (int k = 0; k < 10; k++) begin
      n = $urandom_range(0, 9);
      b = (n < 7) ? 8'(8'h30 + n) : 8'($urandom);
      send_chk($sformatf("rnd%0d", k), b);
    end
    drain("drain2");

    send_chk("b2b_35", 8'h35);
    send(8'h30, 1'b1);
    model(8'h30);
    send(8'h31, 1'b1);
    model(8'h31);
    send(8'h32, 1'b1);
    model(8'h32);
    repeat (2) @(negedge clk);
    chk("b2b_led", 32'(led), 32'h07);
    drain("drain3");

    send_chk("led_36b", 8'h36);
    drain("drain4");
    @(negedge clk) rx = 1'b0;
    repeat (4 * CPB) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    chk("mid_rst_led", 32'(led), 32'd0);
    chk("mid_rst_tx", 32'(tx), 32'd1);
    mled = '0;
    rx = 1'b1;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    send_chk("resync_32", 8'h32);
    drain("drain5");

    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size())
        chk($sformatf("echo%0d", i),
            32'(got_q[i]), 32'(exp_q[i]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mism);
    $finish;
  end

endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 SHALL have parameter CLK_HZ, default 12000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 1000000, UART bit rate; CLKS_PER_BIT = CLK_HZ/BAUD (12 at defaults), computed at elaboration.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port resetn  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port rx  input  1  UART receive line, idle high, asynchronous to clk.
REQ-006 SHALL have port tx  output  1  UART transmit line, idle high.
REQ-007 SHALL have port led  output  5  LED drive, 1 = on.

Function
REQ-008 SHALL pass rx through a 2-flop synchronizer before any use.
REQ-009 SHALL implement a receiver FSM with states IDLE, START, DATA, STOP; frame 8N1, LSB first.
REQ-010 IDLE: a high-to-low transition of synchronized rx enters START and clears the bit counter.
REQ-011 START: at CLKS_PER_BIT/2 clocks, if rx is still low, enter DATA; if rx is high, treat it as a glitch and return to IDLE.
REQ-012 DATA: sample one bit every CLKS_PER_BIT clocks into shift register bits 0..7; after bit 7, enter STOP.
REQ-013 STOP: sample after CLKS_PER_BIT clocks; if high, pulse rx_valid for one clock with the byte; if low (frame error), discard the byte and wait in STOP until rx is high, then return to IDLE.
REQ-014 SHALL update led on the clock after rx_valid, based on the received byte:
- 0x30+n, n=0..4: toggle led[n].
- 0x35: clear all LEDs.
- 0x36: set all LEDs.
- Any other byte: leave led unchanged.
REQ-015 SHALL implement a transmitter FSM with states IDLE, START, DATA, STOP; each bit lasts CLKS_PER_BIT clocks; tx returns high after the stop bit.
REQ-016 The transmitter SHALL start a frame on the clock after a byte is loaded while in IDLE.
REQ-017 SHALL provide a one-byte holding register: a byte arriving while the transmitter is busy is held and sent immediately after the current frame; if the holding register is already full, the new byte is dropped.
REQ-018 Simultaneous events: an rx_valid in the same clock that the transmitter returns to IDLE SHALL be loaded directly into the transmitter.

Reset
REQ-019 While resetn=0 at a clock edge: led=5'b00000, tx=1, both FSMs in IDLE, counters and shift registers zero, holding register empty, rx_valid=0.
REQ-020 Reset asserted mid-frame SHALL abort both frames; after release, the receiver resynchronizes on the next falling edge of rx.

Configuration
REQ-021 Macro ECHO_EN defined: every correctly framed received byte is transmitted back on tx per REQ-016..018.
REQ-022 Macro ECHO_EN undefined: the transmitter and holding register are omitted; tx is tied to 1; LED behaviour is unchanged.

Verification
REQ-023 Reset, then send 0x31 at 1 Mbaud -> led=5'b00010; with ECHO_EN, tx frame 0x31 begins within 2 clocks of the stop-bit sample.
REQ-024 Send 0x31 twice -> led=5'b00000; send 0x36 -> led=5'b11111; send 0x35 -> led=5'b00000.
REQ-025 Send 0x41 -> led unchanged; with ECHO_EN, 0x41 is echoed.
REQ-026 Send 0x30 with the stop bit forced low -> led unchanged, no echo; a following 0x30 sent normally -> led[0]=1.
REQ-027 Drive rx low for 3 clocks only -> no reception, led unchanged; assert resetn=0 mid-frame after led=5'b11111 -> led=0 and tx=1 on the next clock.
REQ-028 Send 3 bytes back-to-back (0x30, 0x31, 0x32) -> led=5'b00111; with ECHO_EN, tx carries 0x30, 0x31, 0x32 in order.
